fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. Holds the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and presents each returned instruction word plus its PC to decode with a valid/stall handshake. Redirects from branch/jump resolution (the decoder's branch_sel path after compare) reload the PC and squash any in-flight or buffered instruction.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- NOP_INST, 32'h0000_0013, value driven on inst_out when no instruction is held (addi x0,x0,0)

- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request this cycle
- imem_addr  output  32  word-aligned fetch address (= pc)
- imem_resp_valid  input  1  read data valid; at most one per accepted request, no earlier than the cycle after acceptance
- imem_resp_data  input  32  instruction word
- redirect  input  1  load new PC, flush
- redirect_pc  input  32  target PC; bits [1:0] ignored and forced to 0
- stall  input  1  decode cannot take inst_out this cycle
- inst_valid  output  1  inst_out/pc_out valid
- inst_out  output  32  instruction to decode
- pc_out  output  32  address of inst_out

## Operation
- Registers: pc (next fetch address), req_pc (address of outstanding request), discard flag, output slot {inst_valid, inst_out, pc_out}, one-entry hold buffer {hold_inst, hold_pc}, FSM state.
- Consume: output slot is emptied in any cycle with inst_valid=1 and stall=0.
- FSM states:
  - S_REQ: imem_req_valid = !redirect. On imem_req_valid && imem_req_ready: req_pc<=pc, pc<=pc+4, discard<=0, go S_WAIT.
  - S_WAIT: imem_req_valid=0. On imem_resp_valid:
    - discard=1: drop data, go S_REQ.
    - output slot empty or being consumed this cycle: load slot with {resp_data, req_pc}, go S_REQ.
    - otherwise: write hold buffer, go S_HOLD.
  - S_HOLD: imem_req_valid=0. When the slot is consumed, move hold buffer into slot (inst_valid stays 1), go S_REQ.
- Redirect (highest priority, any state): pc<=redirect_pc&~3, inst_valid<=0, inst_out<=NOP_INST, hold buffer invalidated. S_REQ stays S_REQ (no request issued this cycle); S_HOLD goes S_REQ; S_WAIT stays S_WAIT with discard<=1, unless imem_resp_valid is also high, in which case the response is dropped and the state goes S_REQ.
- Arithmetic: pc+4 is modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). imem_addr[1:0] is always 0.
- Only one request outstanding; no new request while S_WAIT or S_HOLD.
- imem_resp_valid outside S_WAIT is ignored.

## Timing
- Reset (async, during rst=1): pc=RESET_PC, req_pc=0, discard=0, state S_REQ, inst_valid=0, inst_out=NOP_INST, pc_out=0, hold empty. imem_req_valid=0 while rst=1; imem_addr=RESET_PC.
- First cycle after rst deasserts: imem_req_valid=1, imem_addr=RESET_PC.
- Latency, with ready=1 and response one cycle after acceptance: request at cycle N, response at N+1, inst_valid=1 at N+2. Next request is issued at N+2. Steady-state throughput is one instruction per 2 cycles.
- imem_req_valid depends combinationally on redirect. All other outputs are registered.
- rst asserted mid-transaction: all state returns to reset values immediately. A late response arriving after reset is ignored (state is S_REQ).

## Test plan
- Reset/sequential: RESET_PC=0x100, ready=1, memory returns 0xA0+addr one cycle later. Required: pc_out sequence 0x100, 0x104, 0x108 with matching inst_out; inst_valid first high 2 cycles after the first request.
- Stall/hold: hold stall=1 for 5 cycles while instructions at 0x100 and 0x104 return. Required: slot keeps 0x100, 0x104 goes to hold, no third request. After stall drops: 0x100 consumed, 0x104 presented the next cycle, then a request for 0x108.
- Redirect in S_WAIT: request for 0x104 outstanding, redirect to 0x2002. Required: the late response for 0x104 is dropped, next imem_addr=0x2000, first valid pc_out=0x2000.
- Redirect with simultaneous response: redirect to 0x300 in the same cycle imem_resp_valid is high. Required: data dropped, inst_valid=0 next cycle, next request 0x300.
- Backpressure and wrap: imem_req_ready low for 3 cycles with pc=0xFFFF_FFFC. Required: imem_req_valid held with a stable address; after acceptance the next address is 0x0000_0000.
- Async reset mid-stall in S_HOLD. Required: inst_valid=0 and inst_out=NOP_INST with no clock edge, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of the decoder.
// Holds the PC, issues one instruction-memory read at a time, and hands each
// returned word plus its PC to decode. A redirect reloads the PC and squashes
// anything in flight or buffered.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   imem_req_valid/ready, imem_addr   fetch request channel
//   imem_resp_valid, imem_resp_data   fetch response (one per accepted request)
//   redirect, redirect_pc          branch/jump target load + flush
//   stall                          decode cannot take the output this cycle
//   inst_valid, inst_out, pc_out   instruction slot presented to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        discard_q;
  logic        inst_valid_q;
  logic [31:0] inst_out_q;
  logic [31:0] pc_out_q;
  logic [31:0] hold_inst_q;
  logic [31:0] hold_pc_q;

  logic [31:0] pc_seq_d;
  logic [31:0] redir_pc_d;
  logic        consume;

  // Sequential PC wraps naturally at 2^32; redirect targets are word-aligned.
  assign pc_seq_d   = pc_q + 32'd4;
  assign redir_pc_d = {redirect_pc[31:2], 2'b00};
  assign consume    = inst_valid_q && !stall;

  // Request is suppressed by a same-cycle redirect so the stale PC never issues.
  assign imem_req_valid = !rst && (state_q == S_REQ) && !redirect;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst_out       = inst_out_q;
  assign pc_out         = pc_out_q;

  // Fetch FSM, output slot and hold buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= 32'h0;
      discard_q    <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP_INST;
      pc_out_q     <= 32'h0;
      hold_inst_q  <= NOP_INST;
      hold_pc_q    <= 32'h0;
    end else if (redirect) begin
      pc_q         <= redir_pc_d;
      inst_valid_q <= 1'b0;
      inst_out_q   <= NOP_INST;
      case (state_q)
        S_REQ:  state_q <= S_REQ;
        S_WAIT: begin
          // A response landing with the redirect is stale; otherwise wait it out.
          if (imem_resp_valid) begin
            state_q <= S_REQ;
          end else begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end else begin
      if (consume) begin
        inst_valid_q <= 1'b0;
        inst_out_q   <= NOP_INST;
      end
      case (state_q)
        S_REQ: begin
          if (imem_req_ready) begin
            req_pc_q  <= pc_q;
            pc_q      <= pc_seq_d;
            discard_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (discard_q) begin
              state_q <= S_REQ;
            end else if (!inst_valid_q || consume) begin
              inst_valid_q <= 1'b1;
              inst_out_q   <= imem_resp_data;
              pc_out_q     <= req_pc_q;
              state_q      <= S_REQ;
            end else begin
              hold_inst_q <= imem_resp_data;
              hold_pc_q   <= req_pc_q;
              state_q     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (consume) begin
            inst_valid_q <= 1'b1;
            inst_out_q   <= hold_inst_q;
            pc_out_q     <= hold_pc_q;
            state_q      <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule
